// File: rtl/mmio_lsu.sv
// Load/store initiator for the single-cycle MMIO responder bus.
// Accepts one byte/half/word request, checks alignment, performs one word-aligned
// bus access (held for 1 + WAIT_CYCLES cycles) and returns an extended load result.
module mmio_lsu #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_i_req_valid,
    output logic        lsu_o_req_ready,
    input  logic        lsu_i_req_we,
    input  logic [31:0] lsu_i_req_addr,
    input  logic [1:0]  lsu_i_req_size,
    input  logic        lsu_i_req_unsigned,
    input  logic [31:0] lsu_i_req_wdata,
    output logic        lsu_o_resp_valid,
    output logic [31:0] lsu_o_resp_rdata,
    output logic        lsu_o_resp_err,
    output logic        mmio_o_valid,
    output logic [31:0] mmio_o_addr,
    output logic [3:0]  mmio_o_wmask,
    output logic [31:0] mmio_o_wdata,
    input  logic [31:0] mmio_i_rdata
);

    localparam logic [2:0] WaitLast = 3'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic        accept;
    logic        last_access;

    // Latched request and precomputed bus image
    logic        we_q;
    logic        uns_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  mask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    logic        legal;
    logic [3:0]  mask_new;
    logic [31:0] lane_data;
    logic [31:0] wdata_new;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Decode legality, byte mask and lane-shifted store data of the incoming request
    always_comb begin
        legal     = 1'b0;
        mask_new  = 4'b0000;
        lane_data = 32'h0;
        unique case (lsu_i_req_size)
            2'b00: begin
                legal     = 1'b1;
                mask_new  = 4'b0001 << lsu_i_req_addr[1:0];
                lane_data = {24'h0, lsu_i_req_wdata[7:0]};
            end
            2'b01: begin
                legal     = ~lsu_i_req_addr[0];
                mask_new  = 4'b0011 << lsu_i_req_addr[1:0];
                lane_data = {16'h0, lsu_i_req_wdata[15:0]};
            end
            2'b10: begin
                legal     = (lsu_i_req_addr[1:0] == 2'b00);
                mask_new  = 4'b1111;
                lane_data = lsu_i_req_wdata;
            end
            default: begin
                legal     = 1'b0;
                mask_new  = 4'b0000;
                lane_data = 32'h0;
            end
        endcase
        wdata_new = lane_data << {lsu_i_req_addr[1:0], 3'b000};
        // Loads never present write enables or write data on the bus
        if (!lsu_i_req_we) begin
            mask_new  = 4'b0000;
            wdata_new = 32'h0;
        end
    end

    // Next-state logic and wait counter
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        accept      = 1'b0;
        last_access = (wait_q == WaitLast);
        unique case (state_q)
            StIdle: begin
                if (lsu_i_req_valid) begin
                    accept  = 1'b1;
                    wait_d  = 3'd0;
                    state_d = legal ? StAccess : StResp;
                end
            end
            StAccess: begin
                if (last_access) begin
                    wait_d  = 3'd0;
                    state_d = StResp;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                wait_d  = 3'd0;
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Latch request fields on accept, capture read data on the last access cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'h0;
            mask_q  <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else if (accept) begin
            we_q    <= lsu_i_req_we;
            uns_q   <= lsu_i_req_unsigned;
            err_q   <= ~legal;
            size_q  <= lsu_i_req_size;
            addr_q  <= lsu_i_req_addr;
            mask_q  <= mask_new;
            wdata_q <= wdata_new;
            rdata_q <= 32'h0;
        end else if (state_q == StAccess && last_access) begin
            rdata_q <= mmio_i_rdata;
        end
    end

    // Extract and extend the load result from the captured word
    always_comb begin
        shifted  = rdata_q >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        unique case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Outputs gated by state so the bus is idle-zero outside ACCESS
    always_comb begin
        lsu_o_req_ready  = (state_q == StIdle);
        mmio_o_valid     = (state_q == StAccess);
        mmio_o_addr      = 32'h0;
        mmio_o_wmask     = 4'h0;
        mmio_o_wdata     = 32'h0;
        lsu_o_resp_valid = (state_q == StResp);
        lsu_o_resp_err   = 1'b0;
        lsu_o_resp_rdata = 32'h0;
        if (mmio_o_valid) begin
            mmio_o_addr  = {addr_q[31:2], 2'b00};
            mmio_o_wmask = mask_q;
            mmio_o_wdata = wdata_q;
        end
        if (lsu_o_resp_valid) begin
            lsu_o_resp_err = err_q;
            if (!err_q && !we_q) begin
                lsu_o_resp_rdata = load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mmio_lsu.sv
// Directed-vector bench for mmio_lsu: two instances (WAIT_CYCLES 0 and 3), each with a
// small responder model (LED register at 0x4, 0xBAADC0DE elsewhere).
module tb_mmio_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared request fields; sel picks which instance sees valid and is observed
    logic        sel;
    logic        req_valid, req_we, req_uns;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    logic        ready0, rv0, er0, mv0, ready3, rv3, er3, mv3;
    logic [31:0] rd0, ma0, mw0, mr0, rd3, ma3, mw3, mr3;
    logic [3:0]  mm0, mm3;
    logic [31:0] led0 = 32'h0;
    logic [31:0] led3 = 32'h0;

    mmio_lsu #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .lsu_i_req_valid(req_valid & ~sel), .lsu_o_req_ready(ready0),
        .lsu_i_req_we(req_we), .lsu_i_req_addr(req_addr), .lsu_i_req_size(req_size),
        .lsu_i_req_unsigned(req_uns), .lsu_i_req_wdata(req_wdata), .lsu_o_resp_valid(rv0),
        .lsu_o_resp_rdata(rd0), .lsu_o_resp_err(er0), .mmio_o_valid(mv0), .mmio_o_addr(ma0),
        .mmio_o_wmask(mm0), .mmio_o_wdata(mw0), .mmio_i_rdata(mr0)
    );

    mmio_lsu #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .lsu_i_req_valid(req_valid & sel), .lsu_o_req_ready(ready3),
        .lsu_i_req_we(req_we), .lsu_i_req_addr(req_addr), .lsu_i_req_size(req_size),
        .lsu_i_req_unsigned(req_uns), .lsu_i_req_wdata(req_wdata), .lsu_o_resp_valid(rv3),
        .lsu_o_resp_rdata(rd3), .lsu_o_resp_err(er3), .mmio_o_valid(mv3), .mmio_o_addr(ma3),
        .mmio_o_wmask(mm3), .mmio_o_wdata(mw3), .mmio_i_rdata(mr3)
    );

    // Responder models
    assign mr0 = (ma0 == 32'h4) ? led0 : 32'hBAADC0DE;
    assign mr3 = (ma3 == 32'h4) ? led3 : 32'hBAADC0DE;

    always @(posedge clk) begin
        if (mv0 && ma0 == 32'h4) begin
            for (int b = 0; b < 4; b++) if (mm0[b]) led0[8*b +: 8] <= mw0[8*b +: 8];
        end
        if (mv3 && ma3 == 32'h4) begin
            for (int b = 0; b < 4; b++) if (mm3[b]) led3[8*b +: 8] <= mw3[8*b +: 8];
        end
    end

    // Observed instance
    logic        ready, resp_valid, resp_err, mvalid;
    logic [31:0] resp_rdata, maddr, mwdata;
    logic [3:0]  mmask;
    assign ready      = sel ? ready3 : ready0;
    assign resp_valid = sel ? rv3 : rv0;
    assign resp_err   = sel ? er3 : er0;
    assign resp_rdata = sel ? rd3 : rd0;
    assign mvalid     = sel ? mv3 : mv0;
    assign maddr      = sel ? ma3 : ma0;
    assign mmask      = sel ? mm3 : mm0;
    assign mwdata     = sel ? mw3 : mw0;

    typedef struct {
        logic        sel;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, input logic e, input logic [31:0] rd,
                       input logic [31:0] ma, input logic [3:0] mk, input logic [31:0] mw);
        vec_t v;
        v = '{sel: s, we: we, addr: a, size: sz, uns: u, wdata: wd, err: e, rdata: rd,
              maddr: ma, mask: mk, mwdata: mw};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        sel       = v.sel;
        req_we    = v.we;
        req_addr  = v.addr;
        req_size  = v.size;
        req_uns   = v.uns;
        req_wdata = v.wdata;
        req_valid = 1'b1;
    endtask

    // Observe one transaction from the cycle after accept through ready returning
    task automatic monitor(input vec_t v, input string tag);
        int          w, exp_lat, exp_nv, resp_k, nv;
        logic [31:0] fa, fw, rdv;
        logic [3:0]  fm;
        logic        errv;
        logic        unstable, ready_bad, idle_bad, pulse_bad;
        w         = v.sel ? 3 : 0;
        exp_lat   = v.err ? 1 : 2 + w;
        exp_nv    = v.err ? 0 : 1 + w;
        resp_k    = 0;
        nv        = 0;
        fa        = 32'h0;
        fw        = 32'h0;
        fm        = 4'h0;
        rdv       = 32'h0;
        errv      = 1'b0;
        unstable  = 1'b0;
        ready_bad = 1'b0;
        idle_bad  = 1'b0;
        pulse_bad = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mvalid) begin
                if (nv == 0) begin
                    fa = maddr;
                    fm = mmask;
                    fw = mwdata;
                end else if (maddr !== fa || mmask !== fm || mwdata !== fw) begin
                    unstable = 1'b1;
                end
                nv++;
            end else if (maddr != 32'h0 || mmask != 4'h0 || mwdata != 32'h0) begin
                idle_bad = 1'b1;
            end
            if (!resp_valid && (resp_rdata != 32'h0 || resp_err)) idle_bad = 1'b1;
            if (resp_valid && resp_k == 0) begin
                resp_k = k;
                rdv    = resp_rdata;
                errv   = resp_err;
                if (ready) ready_bad = 1'b1;
            end else if (resp_k != 0) begin
                if (resp_valid) pulse_bad = 1'b1;
                if (!ready) ready_bad = 1'b1;
                break;
            end else if (ready) begin
                ready_bad = 1'b1;
            end
        end
        chk({tag, " latency"}, 32'(resp_k), 32'(exp_lat));
        chk({tag, " mmio_valid cycles"}, 32'(nv), 32'(exp_nv));
        chk({tag, " rdata"}, rdv, v.rdata);
        chk({tag, " err"}, 32'(errv), 32'(v.err));
        chk({tag, " ready"}, 32'(ready_bad), 32'h0);
        chk({tag, " idle outputs"}, 32'(idle_bad), 32'h0);
        chk({tag, " single pulse"}, 32'(pulse_bad), 32'h0);
        chk({tag, " bus stable"}, 32'(unstable), 32'h0);
        if (exp_nv > 0) begin
            chk({tag, " mmio_addr"}, fa, v.maddr);
            chk({tag, " mmio_wmask"}, 32'(fm), 32'(v.mask));
            chk({tag, " mmio_wdata"}, fw, v.mwdata);
        end
    endtask

    initial begin
        vec_t        b;
        int          ready_k, nv;
        logic        seen_resp;

        //   sel   we    addr      sz     uns   wdata          err   rdata          maddr  mask  mwdata
        add(1'b0, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0,        1'b0, 32'hBAADC0DE, 32'h8, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'hB, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFFBA, 32'h8, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'hA, 2'b01, 1'b1, 32'h0,        1'b0, 32'h0000BAAD, 32'h8, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h8, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFFC0DE, 32'h8, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h9, 2'b00, 1'b1, 32'h0,        1'b0, 32'h000000C0, 32'h8, 4'h0, 32'h0);
        add(1'b0, 1'b1, 32'h5, 2'b00, 1'b0, 32'hA5,       1'b0, 32'h0, 32'h4, 4'h2, 32'h0000A500);
        add(1'b0, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0,        1'b0, 32'h0000A500, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b1, 32'h6, 2'b01, 1'b0, 32'hBEEF,     1'b0, 32'h0, 32'h4, 4'hC, 32'hBEEF0000);
        add(1'b0, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0,        1'b0, 32'hBEEFA500, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h7, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFFBE, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b1, 32'h4, 2'b10, 1'b0, 32'h11223344, 1'b0, 32'h0, 32'h4, 4'hF, 32'h11223344);
        add(1'b0, 1'b0, 32'h5, 2'b00, 1'b1, 32'h0,        1'b0, 32'h00000033, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b1, 32'h4, 2'b00, 1'b0, 32'hFFFFFF5A, 1'b0, 32'h0, 32'h4, 4'h1, 32'h0000005A);
        add(1'b0, 1'b0, 32'h4, 2'b01, 1'b0, 32'h0,        1'b0, 32'h0000335A, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h3, 2'b01, 1'b0, 32'h0,        1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 2'b11, 1'b0, 32'h0,        1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h2, 2'b10, 1'b0, 32'h0,        1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, 1'b1, 32'h5, 2'b01, 1'b0, 32'hFFFF,     1'b1, 32'h0, 32'h0, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'h4, 2'b10, 1'b0, 32'h0,        1'b0, 32'h1122335A, 32'h4, 4'h0, 32'h0);
        add(1'b0, 1'b0, 32'hA, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFFBAAD, 32'h8, 4'h0, 32'h0);
        add(1'b1, 1'b0, 32'h8, 2'b10, 1'b0, 32'h0,        1'b0, 32'hBAADC0DE, 32'h8, 4'h0, 32'h0);
        add(1'b1, 1'b1, 32'h4, 2'b01, 1'b0, 32'h1234,     1'b0, 32'h0, 32'h4, 4'h3, 32'h00001234);
        add(1'b1, 1'b0, 32'h4, 2'b00, 1'b0, 32'h0,        1'b0, 32'h00000034, 32'h4, 4'h0, 32'h0);
        add(1'b1, 1'b0, 32'h1, 2'b10, 1'b0, 32'h0,        1'b1, 32'h0, 32'h0, 4'h0, 32'h0);

        sel       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = 2'b00;
        req_uns   = 1'b0;
        req_wdata = 32'h0;
        rst       = 1'b1;
        #12;
        chk("reset ready0", 32'(ready0), 32'h1);
        chk("reset ready3", 32'(ready3), 32'h1);
        chk("reset outputs0", 32'(rv0 | er0 | mv0 | (|rd0) | (|ma0) | (|mm0) | (|mw0)), 32'h0);
        chk("reset outputs3", 32'(rv3 | er3 | mv3 | (|rd3) | (|ma3) | (|mm3) | (|mw3)), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            chk($sformatf("v%0d ready before accept", i), 32'(ready), 32'h1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            monitor(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back on the WAIT_CYCLES=3 instance: second request held until ready
        b = '{sel: 1'b1, we: 1'b0, addr: 32'h4, size: 2'b10, uns: 1'b0, wdata: 32'h0, err: 1'b0,
              rdata: 32'h00001234, maddr: 32'h4, mask: 4'h0, mwdata: 32'h0};
        @(negedge clk);
        drive(vecs[20]);
        @(posedge clk);
        #1 drive(b);
        ready_k   = 0;
        nv        = 0;
        seen_resp = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mvalid) nv++;
            if (resp_valid) seen_resp = 1'b1;
            if (ready) begin
                ready_k = k;
                break;
            end
        end
        chk("b2b ready return", 32'(ready_k), 32'd6);
        chk("b2b first valid cycles", 32'(nv), 32'd4);
        chk("b2b first response", 32'(seen_resp), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        monitor(b, "b2b second");

        // Reset mid-ACCESS of a store: bus clears asynchronously, no response follows
        @(negedge clk);
        b = '{sel: 1'b1, we: 1'b1, addr: 32'h4, size: 2'b10, uns: 1'b0, wdata: 32'hDEADBEEF,
              err: 1'b0, rdata: 32'h0, maddr: 32'h4, mask: 4'hF, mwdata: 32'hDEADBEEF};
        drive(b);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst pre valid", 32'(mvalid), 32'h1);
        chk("rst pre wmask", 32'(mmask), 32'hF);
        #2 rst = 1'b1;
        #1;
        chk("rst async valid", 32'(mvalid), 32'h0);
        chk("rst async wmask", 32'(mmask), 32'h0);
        chk("rst async wdata", mwdata, 32'h0);
        chk("rst async addr", maddr, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        seen_resp = 1'b0;
        chk("rst release ready", 32'(ready), 32'h1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        chk("rst no response", 32'(seen_resp), 32'h0);
        chk("rst ready idle", 32'(ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mmio_lsu.md
# mmio_lsu

Load/store initiator that drives the single-cycle MMIO responder bus on behalf of the core's memory stage. It accepts one byte/half/word request at a time over a valid/ready handshake and checks alignment. It then issues a word-aligned bus access with the correct byte write mask and lane-shifted write data, and returns a sign- or zero-extended load result with a one-cycle response pulse. It sits between the core datapath and the MMIO address decoder.

## Interface
- WAIT_CYCLES, 0: extra cycles `mmio_o_valid` is held before `mmio_i_rdata` is sampled (legal range 0..7).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- lsu_i_req_valid  in  1  core request valid.
- lsu_o_req_ready  out  1  block can accept a request (high only in IDLE).
- lsu_i_req_we  in  1  1 = store, 0 = load.
- lsu_i_req_addr  in  32  byte address.
- lsu_i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- lsu_i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- lsu_i_req_wdata  in  32  store data, right-aligned.
- lsu_o_resp_valid  out  1  one-cycle response pulse.
- lsu_o_resp_rdata  out  32  extended load data; 0 for stores and errors.
- lsu_o_resp_err  out  1  misaligned or illegal size; qualified by `lsu_o_resp_valid`.
- mmio_o_valid  out  1  bus access active.
- mmio_o_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
- mmio_o_wmask  out  4  byte write enables; 0000 for loads.
- mmio_o_wdata  out  32  lane-shifted store data.
- mmio_i_rdata  in  32  responder read data, combinational from `mmio_o_addr`.

## Operation
- FSM states are IDLE, ACCESS and RESP. Reset forces IDLE.
- IDLE:
  - `lsu_o_req_ready` = 1.
  - On `lsu_i_req_valid`, latch all request fields.
  - If the request is legal, go to ACCESS. Otherwise go to RESP with err = 1 and perform no bus access.
- Legality:
  - size 11 is illegal.
  - A half access with addr[0] = 1 is illegal.
  - A word access with addr[1:0] != 00 is illegal.
- ACCESS:
  - Drive `mmio_o_valid` = 1 for exactly 1 + WAIT_CYCLES cycles, tracked by a 3-bit wait counter.
  - All `mmio_o_*` outputs stay stable for the whole access.
  - On the last ACCESS cycle, capture `mmio_i_rdata` and go to RESP.
- Store mask, with o = addr[1:0]:
  - byte: 0001 << o.
  - half: 0011 << o.
  - word: 1111.
- Store data: wdata << (8·o), with unselected lanes 0.
- Load extract:
  - Shift the captured word right by 8·o.
  - Take the low 8, 16 or 32 bits according to size.
  - Sign-extend or zero-extend according to `lsu_i_req_unsigned`.
- RESP:
  - `lsu_o_resp_valid` = 1 for one cycle, then IDLE.
  - There is no response back-pressure; the core must take the pulse.
- Outside ACCESS, `mmio_o_valid`, `mmio_o_addr`, `mmio_o_wmask` and `mmio_o_wdata` are 0, so no spurious writes are possible.
- Outside RESP, `lsu_o_resp_rdata` and `lsu_o_resp_err` are 0.

## Timing
- Reset values: state IDLE, `lsu_o_req_ready` = 1, every other output 0, wait counter 0.
- Request accepted at edge N:
  - ACCESS occupies cycles N+1 … N+1+WAIT_CYCLES.
  - `lsu_o_resp_valid` is high in cycle N+2+WAIT_CYCLES.
  - `lsu_o_req_ready` returns high the following cycle.
- Error request accepted at edge N: `lsu_o_resp_valid` and `lsu_o_resp_err` are high in cycle N+1, with no `mmio_o_valid` cycle.
- Throughput: one request per 3+WAIT_CYCLES cycles (2 cycles for an error).
- `lsu_i_req_valid` while ready = 0 is ignored. The core holds the request until it sees ready.
- `mmio_o_*` are driven from registers; there is no combinational path from `lsu_i_*` to `mmio_o_*`.
- Reset asserted mid-ACCESS or mid-RESP:
  - Outputs clear asynchronously and the transaction is dropped with no response.
  - A store in progress may already have been written by the responder.

## Test plan
- Aligned word load from 0x0000_0008 (unmapped), WAIT_CYCLES = 0 -> `mmio_o_valid` high 1 cycle, `mmio_o_wmask` = 0000, response 2 cycles after accept with rdata = 0xBAAD_C0DE, err = 0.
- Signed byte load from 0x0000_000B with responder data 0xBAAD_C0DE -> rdata = 0xFFFF_FFBA. Unsigned half load from 0x0000_000A -> rdata = 0x0000_BAAD.
- Store byte 0xA5 to 0x0000_0005 -> `mmio_o_addr` = 0x0000_0004, `mmio_o_wmask` = 0010, `mmio_o_wdata` = 0x0000_A500; response rdata = 0, err = 0. A follow-up word read of 0x4 returns 0x0000_A500 (LED register).
- Half load at 0x0000_0003, and size = 11 at 0x0 -> err = 1 in the cycle after accept, `mmio_o_valid` never asserted, rdata = 0.
- WAIT_CYCLES = 3: word load -> `mmio_o_valid` high exactly 4 cycles with stable address, response at accept+5, ready low throughout. A back-to-back request is held and accepted only after the response.
- Assert rst during ACCESS of a store to 0x4 -> `mmio_o_valid` and `mmio_o_wmask` drop to 0 without waiting for a clock edge. No `lsu_o_resp_valid` appears. `lsu_o_req_ready` = 1 after reset release.
